// File: rtl/crash_course_cpu_pkg.sv
// Shared types and constants for the crash-course CPU program memory.
package crash_course_cpu_pkg;

   localparam int PROGRAM_ADDR_WIDTH = 8;
   localparam int PROGRAM_DEPTH      = 256;
   localparam int INSTR_NOP          = 0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOADING = 2'd1,
      READY   = 2'd2,
      RUNNING = 2'd3
   } program_memory_state_t;

endpackage

// File: rtl/crash_course_cpu_program_memory_array.sv
// Plain two-port program RAM: one write port, one registered read port.
module crash_course_cpu_program_memory_array
   import crash_course_cpu_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = PROGRAM_ADDR_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  wr_en_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  rd_en_i,
   input  logic                  rd_clr_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o
);

   logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] rd_data_q;

   // Storage is deliberately not reset so a partial program survives reset.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // rd_clr_i forces a NOP out while no complete program is resident.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_data_q <= DATA_WIDTH'(INSTR_NOP);
      end else if (rd_en_i) begin
         rd_data_q <= rd_clr_i ? DATA_WIDTH'(INSTR_NOP) : mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/crash_course_cpu_program_memory.sv
// Program store with valid/ready load port, 1-cycle fetch and CPU start-up sequencing.
module crash_course_cpu_program_memory
   import crash_course_cpu_pkg::*;
#(
   parameter int INSTR_WIDTH = 16,
   parameter int ADDR_WIDTH  = PROGRAM_ADDR_WIDTH
) (
   input  logic                   clk,
   input  logic                   clk_en,
   input  logic                   sync_rst,
   input  logic                   load_start,
   input  logic                   load_valid,
   input  logic [INSTR_WIDTH-1:0] load_data,
   input  logic                   load_last,
   output logic                   load_ready,
   input  logic                   run_request,
   input  logic                   halt_request,
   input  logic [ADDR_WIDTH-1:0]  program_counter,
   output logic [INSTR_WIDTH-1:0] instruction,
   output logic                   system_start,
   output logic                   system_enabled,
   output logic                   program_loaded,
   output logic [ADDR_WIDTH:0]    load_count,
   output logic                   load_overflow,
   output program_memory_state_t  state_debug
);

   // Load handshake: a beat transfers on a clk_en cycle where load_valid and
   // load_ready are both high; load_ready depends only on state, never on load_valid.
   program_memory_state_t  state_q;
   logic [ADDR_WIDTH-1:0]  load_pointer_q;
   logic [ADDR_WIDTH:0]    load_count_q;
   logic                   load_overflow_q;
   logic                   system_start_q;
   logic                   system_enabled_q;
   logic                   wr_en;
   logic                   rd_clr;

   // A load_start in LOADING restarts the load and drops any same-cycle beat.
   assign wr_en  = clk_en && (state_q == LOADING) && load_valid && !load_start;
   assign rd_clr = (state_q == IDLE) || (state_q == LOADING);

   always_ff @(posedge clk) begin
      if (sync_rst) begin
         state_q          <= IDLE;
         load_pointer_q   <= '0;
         load_count_q     <= '0;
         load_overflow_q  <= 1'b0;
         system_start_q   <= 1'b0;
         system_enabled_q <= 1'b0;
      end else if (clk_en) begin
         system_start_q   <= 1'b0;
         system_enabled_q <= (state_q == RUNNING) && !halt_request;
         case (state_q)
            IDLE: begin
               if (load_start) begin
                  state_q         <= LOADING;
                  load_pointer_q  <= '0;
                  load_count_q    <= '0;
                  load_overflow_q <= 1'b0;
               end
            end
            LOADING: begin
               if (load_start) begin
                  load_pointer_q  <= '0;
                  load_count_q    <= '0;
                  load_overflow_q <= 1'b0;
               end else if (load_valid) begin
                  load_pointer_q <= load_pointer_q + 1'b1;
                  load_count_q   <= load_count_q + 1'b1;
                  if (load_last) begin
                     state_q <= READY;
                  end else if (load_pointer_q == '1) begin
                     state_q         <= READY;
                     load_overflow_q <= 1'b1;
                  end
               end
            end
            READY: begin
               if (load_start) begin
                  state_q         <= LOADING;
                  load_pointer_q  <= '0;
                  load_count_q    <= '0;
                  load_overflow_q <= 1'b0;
               end else if (run_request) begin
                  state_q        <= RUNNING;
                  system_start_q <= 1'b1;
               end
            end
            RUNNING: begin
               if (halt_request) begin
                  state_q <= READY;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   crash_course_cpu_program_memory_array #(
      .DATA_WIDTH (INSTR_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_array (
      .clk_i     (clk),
      .rst_i     (sync_rst),
      .wr_en_i   (wr_en),
      .wr_addr_i (load_pointer_q),
      .wr_data_i (load_data),
      .rd_en_i   (clk_en),
      .rd_clr_i  (rd_clr),
      .rd_addr_i (program_counter),
      .rd_data_o (instruction)
   );

   assign load_ready     = (state_q == LOADING);
   assign program_loaded = (state_q == READY) || (state_q == RUNNING);
   assign system_start   = system_start_q;
   assign system_enabled = system_enabled_q;
   assign load_count     = load_count_q;
   assign load_overflow  = load_overflow_q;
   assign state_debug    = state_q;

endmodule

// File: doc/crash_course_cpu_program_memory.md
Name: crash_course_cpu_program_memory

Overview:
Instruction-side responder to the CPU program counter. It holds a 256-entry program store that is filled through a valid/ready load port. Once loaded, it returns the instruction addressed by program_counter one clk_en cycle later. It also sequences CPU start-up by generating the system_start pulse and the system_enabled level that the program counter consumes.

Parameters:
INSTR_WIDTH, 16, width of one instruction word.
ADDR_WIDTH, 8, program address width; fixed to match program_counter, so depth = 2**ADDR_WIDTH = 256.

Ports:
clk  input  1  system clock
clk_en  input  1  global clock enable; all state and memory updates are qualified by it, except reset
sync_rst  input  1  synchronous active-high reset
load_start  input  1  pulse: begin loading the program from address 0
load_valid  input  1  load beat valid
load_data  input  INSTR_WIDTH  instruction word to write
load_last  input  1  marks the final beat of the program
load_ready  output  1  store accepts a load beat
run_request  input  1  pulse: start executing the loaded program
halt_request  input  1  pulse: stop execution and return to READY
program_counter  input  ADDR_WIDTH  fetch address from the program counter
instruction  output  INSTR_WIDTH  registered instruction at program_counter
system_start  output  1  one-cycle start pulse to the program counter and CPU
system_enabled  output  1  CPU run enable
program_loaded  output  1  a complete program is resident
load_count  output  ADDR_WIDTH+1  number of words written in the last load (0..256)
load_overflow  output  1  sticky: load wrapped past address 255 without load_last

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on sync_rst.
- Reset values:
  - State machine goes to IDLE.
  - load_pointer = 0, load_count = 0, load_overflow = 0.
  - instruction = 0; load_ready, system_start, system_enabled and program_loaded = 0.
  - Memory contents are not reset.
- State machine: IDLE, LOADING, READY, RUNNING. Transitions happen only on cycles with clk_en=1.
- IDLE:
  - load_start -> LOADING.
  - On entry to LOADING: load_pointer=0, load_count=0, load_overflow=0.
- LOADING:
  - load_ready=1.
  - A beat is load_valid && load_ready && clk_en.
  - On a beat: mem[load_pointer] <= load_data, load_pointer+1 (wraps 255->0), load_count+1.
  - Beat with load_last=1 -> READY.
  - Beat at load_pointer=255 with load_last=0 -> READY, load_overflow=1, load_count=256.
  - load_start during LOADING restarts the load (pointer and count cleared); a same-cycle beat is dropped.
- READY:
  - program_loaded=1.
  - run_request -> RUNNING, and system_start=1 for exactly that one clk_en cycle.
  - load_start -> LOADING; it takes precedence over a simultaneous run_request.
- RUNNING:
  - system_enabled=1 from the cycle after system_start.
  - halt_request -> READY; system_enabled drops on the next cycle.
  - load_start and run_request are ignored.
  - program_loaded stays 1.
- Fetch path:
  - In READY and RUNNING, instruction <= mem[program_counter] every clk_en cycle. Latency is 1 cycle.
  - In IDLE and LOADING, instruction <= 0 (NOP).
  - Writes occur only in LOADING, so there is no read/write collision.
- clk_en=0: all registers hold, including the instruction and the system_start pulse, which is stretched until the next clk_en cycle.
- Reset mid-load or mid-run: returns to IDLE immediately. A partially written memory is left as is, and program_loaded=0 until a new load completes.
- Empty program: unreachable, because LOADING exits only on a beat. load_count >= 1 in READY.

Decomposition:
- Shared package crash_course_cpu_pkg contains:
  - program_memory_state_t enum (IDLE, LOADING, READY, RUNNING)
  - PROGRAM_ADDR_WIDTH = 8
  - PROGRAM_DEPTH = 256
  - INSTR_NOP = 0
- One sub-module, crash_course_cpu_program_memory_array: single write port and one registered read port (plain 2-port RAM) with write enable, write address/data and read enable/address. The control FSM stays in the top module.

Test Plan:
- Reset, then load 4 words 0x1111, 0x2222, 0x3333, 0x4444 with load_last on the 4th -> state READY, load_count=4, program_loaded=1, load_ready=0, load_overflow=0.
- In READY, pulse run_request, then drive program_counter 0,1,2,3 -> system_start high for one cycle; system_enabled=1 from the next cycle; instruction = 0x1111, 0x2222, 0x3333, 0x4444 each one cycle after its address.
- Load 256 beats with no load_last -> READY after the 256th beat, load_count=256, load_overflow=1; mem[255] holds beat 256.
- Toggle clk_en low for 3 cycles during LOADING with load_valid=1 -> no beats taken, load_count unchanged. Toggle it low in the cycle system_start asserts -> the pulse holds until clk_en returns and is counted once.
- While RUNNING, pulse load_start and run_request -> both ignored. Then pulse halt_request -> READY, system_enabled=0, instruction keeps tracking mem[program_counter].
- Assert sync_rst mid-load at load_pointer=2 -> all outputs 0, state IDLE. A new load of 1 word 0xABCD with load_last -> load_count=1; a fetch at address 0 in READY returns 0xABCD.
